// File: rtl/instr_pkg.sv
// Shared encoding constants, opcode enum and decoded-field struct for the instruction decode queue.
// The optional DECODE_ILLEGAL_CHECK_EN feature compares opcodes against NUM_OPCODES.
package instr_pkg;

    localparam int INSTR_W     = 21;
    localparam int NUM_OPCODES = 12;

    localparam int OPC_HI = 20;
    localparam int OPC_LO = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 12;
    localparam int RN_HI  = 11;
    localparam int RN_LO  = 8;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    typedef enum logic [4:0] {
        ADD = 5'd0,
        SUB = 5'd1,
        AND = 5'd2,
        OR  = 5'd3,
        XOR = 5'd4,
        SLL = 5'd5,
        SRL = 5'd6,
        SRA = 5'd7,
        MOV = 5'd8,
        LDI = 5'd9,
        LD  = 5'd10,
        ST  = 5'd11
    } opcode_e;

    typedef struct packed {
        logic [4:0] opcode;
        logic [3:0] rd;
        logic [3:0] rn;
        logic [7:0] imm;
    } instr_fields_t;

    // Pure bit slicing: the immediate is passed through untouched.
    function automatic instr_fields_t slice_fields(input logic [INSTR_W-1:0] word);
        instr_fields_t f;
        f.opcode = word[OPC_HI:OPC_LO];
        f.rd     = word[RD_HI:RD_LO];
        f.rn     = word[RN_HI:RN_LO];
        f.imm    = word[IMM_HI:IMM_LO];
        return f;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// First-word-fall-through FIFO: register storage, wrapping pointers, occupancy count.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 21
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_valid,
    input  logic [WIDTH-1:0]         push_data,
    output logic                     push_ready,
    output logic                     pop_valid,
    input  logic                     pop_ready,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic [AW:0]      count_next;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    assign full       = (count_reg == FULL_COUNT);
    assign empty      = (count_reg == '0);
    assign push_ready = !full;
    assign pop_valid  = !empty;
    assign push       = push_valid && !full;
    assign pop        = pop_ready && !empty;
    assign head_data  = mem_reg[rd_ptr_reg];
    assign count      = count_reg;

    always_comb begin
        count_next = count_reg;
        unique case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
        end
    end

    // Storage is cleared on reset so the head fields read zero while empty.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            localparam logic [AW-1:0] SLOT = AW'(gi);
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem_reg[gi] <= '0;
                end else if (push && (wr_ptr_reg == SLOT)) begin
                    mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/instr_decode_queue.sv
// Instruction queue between encoder and register-read stage; splits the head word into fields.
// Define DECODE_ILLEGAL_CHECK_EN to flag head opcodes >= NUM_OPCODES on out_illegal.
module instr_decode_queue
    import instr_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [INSTR_W-1:0]       in_instr,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [4:0]               out_opcode,
    output logic [3:0]               out_rd,
    output logic [3:0]               out_rn,
    output logic [7:0]               out_imm,
    output logic                     out_illegal,
    output logic [$clog2(DEPTH):0]   count
);

    logic [INSTR_W-1:0] head_word;
    instr_fields_t      head_fields;

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (in_valid),
        .push_data  (in_instr),
        .push_ready (in_ready),
        .pop_valid  (out_valid),
        .pop_ready  (out_ready),
        .head_data  (head_word),
        .count      (count)
    );

    assign head_fields = slice_fields(head_word);
    assign out_opcode  = head_fields.opcode;
    assign out_rd      = head_fields.rd;
    assign out_rn      = head_fields.rn;
    assign out_imm     = head_fields.imm;

    // Illegal entries are still delivered; downstream decides whether to trap.
`ifdef DECODE_ILLEGAL_CHECK_EN
    assign out_illegal = out_valid && (head_fields.opcode >= 5'(NUM_OPCODES));
`else
    assign out_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_instr_decode_queue.sv
// Scoreboard bench for instr_decode_queue: directed pushes enqueue hand-computed fields,
// a negedge monitor pops and compares on every handshake and checks hold stability.
module tb_instr_decode_queue;

    localparam int DEPTH = 4;
`ifdef DECODE_ILLEGAL_CHECK_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [20:0] in_instr;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_opcode;
    logic [3:0]  out_rd;
    logic [3:0]  out_rn;
    logic [7:0]  out_imm;
    logic        out_illegal;
    logic [2:0]  count;

    instr_decode_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_instr    (in_instr),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_opcode  (out_opcode),
        .out_rd      (out_rd),
        .out_rn      (out_rn),
        .out_imm     (out_imm),
        .out_illegal (out_illegal),
        .count       (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [20:0] word;
        logic [4:0]  opc;
        logic [3:0]  rd;
        logic [3:0]  rn;
        logic [7:0]  imm;
        bit          ill;
    } vec_t;

    vec_t vecs[8];
    vec_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Drive one word for a single cycle; acc reports whether it was accepted.
    task automatic push_vec(input int i, output bit acc);
        vec_t v;
        in_valid = 1'b1;
        in_instr = vecs[i].word;
        @(negedge clk);
        acc = in_ready;
        if (acc) begin
            v     = vecs[i];
            v.ill = v.ill & ILL_EN;
            sb.push_back(v);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor
    bit          hold_pending = 1'b0;
    logic [20:0] held;
    vec_t        e;

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                check("hold_stable", {11'd0, out_opcode, out_rd, out_rn, out_imm}, {11'd0, held});
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_pop", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    $display("pop word=%06h opc=%0d rd=%0d rn=%0d imm=%02h ill=%0b",
                             e.word, out_opcode, out_rd, out_rn, out_imm, out_illegal);
                    check("pop_opcode",  {27'd0, out_opcode}, {27'd0, e.opc});
                    check("pop_rd",      {28'd0, out_rd},     {28'd0, e.rd});
                    check("pop_rn",      {28'd0, out_rn},     {28'd0, e.rn});
                    check("pop_imm",     {24'd0, out_imm},    {24'd0, e.imm});
                    check("pop_illegal", {31'd0, out_illegal}, {31'd0, e.ill});
                end
            end
            hold_pending = out_valid && !out_ready;
            held         = {out_opcode, out_rd, out_rn, out_imm};
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        bit pat[4];

        vecs[0] = '{21'h004503, 5'd0,  4'h4, 4'h5, 8'h03, 1'b0};
        vecs[1] = '{21'h0312A5, 5'd3,  4'h1, 4'h2, 8'hA5, 1'b0};
        vecs[2] = '{21'h0BF0FF, 5'd11, 4'hF, 4'h0, 8'hFF, 1'b0};
        vecs[3] = '{21'h079E80, 5'd7,  4'h9, 4'hE, 8'h80, 1'b0};
        vecs[4] = '{21'h012344, 5'd1,  4'h2, 4'h3, 8'h44, 1'b0};
        vecs[5] = '{21'h146701, 5'd20, 4'h6, 4'h7, 8'h01, 1'b1};
        vecs[6] = '{21'h1FABC3, 5'd31, 4'hA, 4'hB, 8'hC3, 1'b1};
        vecs[7] = '{21'h02017F, 5'd2,  4'h0, 4'h1, 8'h7F, 1'b0};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count",     {29'd0, count},       32'd0);
        check("rst_out_valid", {31'd0, out_valid},   32'd0);
        check("rst_in_ready",  {31'd0, in_ready},    32'd1);
        check("rst_illegal",   {31'd0, out_illegal}, 32'd0);
        #3 rst_n = 1'b1;

        // Single push, first edge after reset release
        push_vec(0, acc);
        check("single_acc",       {31'd0, acc},        32'd1);
        check("single_out_valid", {31'd0, out_valid},  32'd1);
        check("single_opcode",    {27'd0, out_opcode}, 32'd0);
        check("single_rd",        {28'd0, out_rd},     32'd4);
        check("single_rn",        {28'd0, out_rn},     32'd5);
        check("single_imm",       {24'd0, out_imm},    32'h03);
        check("single_count",     {29'd0, count},      32'd1);

        // Reset mid-stream with 3 entries queued
        push_vec(1, acc);
        push_vec(2, acc);
        check("pre_rst_count", {29'd0, count}, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_count",     {29'd0, count},       32'd0);
        check("mid_rst_out_valid", {31'd0, out_valid},   32'd0);
        check("mid_rst_in_ready",  {31'd0, in_ready},    32'd1);
        check("mid_rst_fields",    {11'd0, out_opcode, out_rd, out_rn, out_imm}, 32'd0);
        check("mid_rst_illegal",   {31'd0, out_illegal}, 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        check("rst_hold_count", {29'd0, count}, 32'd0);
        #3 rst_n = 1'b1;

        // Fill with out_ready low, fifth word refused
        for (int i = 1; i <= 4; i++) begin
            push_vec(i, acc);
            check("fill_acc", {31'd0, acc}, 32'd1);
        end
        check("full_count",    {29'd0, count},    32'd4);
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        push_vec(6, acc);
        check("fifth_rejected",   {31'd0, acc},   32'd0);
        check("full_count_after", {29'd0, count}, 32'd4);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("drain_count",     {29'd0, count},     32'd0);
        check("drain_out_valid", {31'd0, out_valid}, 32'd0);

        // Concurrent push/pop across pointer wrap
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            push_vec(k % 8, acc);
            check("stream_acc",   {31'd0, acc},   32'd1);
            check("stream_count", {29'd0, count}, 32'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("stream_end_count", {29'd0, count}, 32'd0);

        // Backpressure 1,0,0,1
        push_vec(1, acc);
        push_vec(2, acc);
        push_vec(3, acc);
        check("bp_count_start", {29'd0, count}, 32'd3);
        for (int k = 0; k < 4; k++) begin
            out_ready = pat[k];
            @(posedge clk);
            #1;
        end
        check("bp_count_mid", {29'd0, count}, 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_count_end", {29'd0, count}, 32'd0);

        // Illegal opcode flagging
        push_vec(5, acc);
        check("op20_opcode",  {27'd0, out_opcode},  32'd20);
        check("op20_illegal", {31'd0, out_illegal}, {31'd0, ILL_EN});
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        push_vec(2, acc);
        check("op11_opcode",  {27'd0, out_opcode},  32'd11);
        check("op11_illegal", {31'd0, out_illegal}, 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);

        check("sb_empty",    sb.size(),          32'd0);
        check("final_count", {29'd0, count},     32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
